// File: rtl/clk_step_controller_if.sv
// rtl/clk_step_controller_if.sv - run/step/halt request and cpu tick bundle for clk_step_controller
// Ports (signals):
//   run        level request for free-running ticks (asynchronous source)
//   step       single-step request, rising edge significant (asynchronous source)
//   halt       synchronous CPU halt indication, level
//   cpu_en     one-cycle clock-enable pulse for the CPU datapath
//   tick_count number of cpu_en pulses since reset, wraps at 16 bits
//   state      controller state: 00 idle, 01 run, 10 step, 11 halt
// master drives the requests and observes the controller; slave is the controller.
interface clk_step_controller_if;
    logic        run;
    logic        step;
    logic        halt;
    logic        cpu_en;
    logic [15:0] tick_count;
    logic [1:0]  state;

    modport master (
        output run, step, halt,
        input  cpu_en, tick_count, state
    );

    modport slave (
        input  run, step, halt,
        output cpu_en, tick_count, state
    );
endinterface

// File: rtl/clk_step_controller.sv
// rtl/clk_step_controller.sv - run/single-step CPU clock-enable generator with halt
// Ports:
//   clkin  system clock, all state updates on the rising edge
//   reset  asynchronous active-low reset
//   bus    clk_step_controller_if.slave: run/step/halt in, cpu_en/tick_count/state out
// Parameters:
//   IN_CLK_FRQ   clkin frequency in Hz
//   OUT_CLK_FRQ  CPU tick rate in Hz; IN_CLK_FRQ/OUT_CLK_FRQ must be at least 2
module clk_step_controller #(
    parameter int IN_CLK_FRQ  = 1000000,
    parameter int OUT_CLK_FRQ = 10
) (
    input  logic                  clkin,
    input  logic                  reset,
    clk_step_controller_if.slave  bus
);

    localparam logic [31:0] PERIOD = 32'(IN_CLK_FRQ / OUT_CLK_FRQ);
    localparam logic [31:0] LAST   = PERIOD - 32'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_t;

    logic        run_s1, run_s2;
    logic        step_s1, step_s2, step_d;
    state_t      state_q, state_n;
    logic [31:0] cnt_q, cnt_n;
    logic        cpu_en_q, cpu_en_n;
    logic [15:0] tick_q;
    logic        step_edge;
    logic        wrap;

    // Two-flop synchronizers for the asynchronous switch/button inputs, plus
    // one extra flop on step so its rising edge is seen for exactly one cycle.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            run_s1  <= 1'b0;
            run_s2  <= 1'b0;
            step_s1 <= 1'b0;
            step_s2 <= 1'b0;
            step_d  <= 1'b0;
        end else begin
            run_s1  <= bus.run;
            run_s2  <= run_s1;
            step_s1 <= bus.step;
            step_s2 <= step_s1;
            step_d  <= step_s2;
        end
    end

    assign step_edge = step_s2 & ~step_d;
    assign wrap      = (cnt_q == LAST);

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 32'd0;
            cpu_en_q <= 1'b0;
            tick_q   <= 16'd0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            cpu_en_q <= cpu_en_n;
            if (cpu_en_n) begin
                tick_q <= tick_q + 16'd1;
            end
        end
    end

    // The counter is zero whenever a state is entered: every transition below
    // also clears it, so the first pulse lands PERIOD edges after entry.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        cpu_en_n = 1'b0;
        if (bus.halt) begin
            // Halt beats everything, including a wrap on this same edge.
            state_n = S_HALT;
            cnt_n   = 32'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_n = 32'd0;
                    if (run_s2) begin
                        state_n = S_RUN;
                    end else if (step_edge) begin
                        state_n = S_STEP;
                    end
                end
                S_RUN: begin
                    if (!run_s2) begin
                        // Dropping run abandons a pending wrap: no pulse.
                        state_n = S_IDLE;
                        cnt_n   = 32'd0;
                    end else if (wrap) begin
                        cpu_en_n = 1'b1;
                        cnt_n    = 32'd0;
                    end else begin
                        cnt_n = cnt_q + 32'd1;
                    end
                end
                S_STEP: begin
                    if (wrap) begin
                        cpu_en_n = 1'b1;
                        cnt_n    = 32'd0;
                        state_n  = run_s2 ? S_RUN : S_IDLE;
                    end else begin
                        cnt_n = cnt_q + 32'd1;
                    end
                end
                S_HALT: begin
                    cnt_n = 32'd0;
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = 32'd0;
                end
            endcase
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.tick_count = tick_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_clk_step_controller.sv
// tb/tb_clk_step_controller.sv - directed self-checking bench for clk_step_controller
module tb_clk_step_controller;

    logic clkin;
    logic reset;
    int   checks;
    int   errors;

    clk_step_controller_if bus ();

    clk_step_controller #(
        .IN_CLK_FRQ  (100),
        .OUT_CLK_FRQ (10)
    ) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Advance n rising edges; inputs are driven and outputs sampled 1 ns after.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        bus.run  = 1'b0;
        bus.step = 1'b0;
        bus.halt = 1'b0;

        #2;
        chk("reset_state",  32'(bus.state), 32'h0);
        chk("reset_cpu_en", 32'(bus.cpu_en), 32'h0);
        chk("reset_tick",   32'(bus.tick_count), 32'h0);
        cyc(2);
        reset = 1'b1;

        // Free run: RUN at edge 3, pulses at 13/23/33/43.
        bus.run = 1'b1;
        cyc(2);
        chk("run_not_yet_e2", 32'(bus.state), 32'h0);
        cyc(1);
        chk("run_entered_e3", 32'(bus.state), 32'h1);
        cyc(9);
        chk("run_no_pulse_e12", 32'(bus.cpu_en), 32'h0);
        cyc(1);
        chk("run_pulse_e13", 32'(bus.cpu_en), 32'h1);
        chk("run_tick_e13",  32'(bus.tick_count), 32'h1);
        cyc(1);
        chk("run_pulse_one_cycle", 32'(bus.cpu_en), 32'h0);
        cyc(29);
        chk("run_pulse_e43", 32'(bus.cpu_en), 32'h1);
        chk("run_tick_e43",  32'(bus.tick_count), 32'h4);

        // Run drop seen by the FSM exactly at the edge where the counter is 9.
        cyc(7);
        bus.run = 1'b0;
        cyc(2);
        chk("drop_still_run_e52", 32'(bus.state), 32'h1);
        cyc(1);
        chk("drop_idle_e53",   32'(bus.state), 32'h0);
        chk("drop_no_pulse",   32'(bus.cpu_en), 32'h0);
        chk("drop_tick_held",  32'(bus.tick_count), 32'h4);

        // Single step with a second step press while still in STEP.
        bus.step = 1'b1;
        cyc(3);
        chk("step_entered", 32'(bus.state), 32'h2);
        cyc(2);
        bus.step = 1'b0;
        cyc(3);
        bus.step = 1'b1;
        cyc(2);
        bus.step = 1'b0;
        cyc(2);
        chk("step_no_pulse_r12", 32'(bus.cpu_en), 32'h0);
        chk("step_state_r12",    32'(bus.state), 32'h2);
        cyc(1);
        chk("step_pulse_r13", 32'(bus.cpu_en), 32'h1);
        chk("step_tick_r13",  32'(bus.tick_count), 32'h5);
        chk("step_back_idle", 32'(bus.state), 32'h0);
        cyc(12);
        chk("step_no_extra_tick", 32'(bus.tick_count), 32'h5);
        chk("step_stay_idle",     32'(bus.state), 32'h0);

        // tick_count wrap from 0xFFFF.
        bus.run = 1'b1;
        cyc(3);
        chk("wrap_run_entered", 32'(bus.state), 32'h1);
        force dut.tick_q = 16'hFFFF;
        #1;
        release dut.tick_q;
        cyc(10);
        chk("wrap_pulse", 32'(bus.cpu_en), 32'h1);
        chk("wrap_tick",  32'(bus.tick_count), 32'h0);

        // Halt at the edge where the counter would wrap.
        cyc(9);
        bus.halt = 1'b1;
        cyc(1);
        chk("halt_state",    32'(bus.state), 32'h3);
        chk("halt_no_pulse", 32'(bus.cpu_en), 32'h0);
        chk("halt_tick",     32'(bus.tick_count), 32'h0);
        bus.halt = 1'b0;
        bus.run  = 1'b0;
        bus.step = 1'b1;
        cyc(5);
        bus.run  = 1'b1;
        bus.step = 1'b0;
        cyc(15);
        chk("halt_sticky_state", 32'(bus.state), 32'h3);
        chk("halt_sticky_tick",  32'(bus.tick_count), 32'h0);

        // Reset leaves HALT asynchronously.
        #2;
        reset = 1'b0;
        #1;
        chk("halt_reset_async", 32'(bus.state), 32'h0);
        bus.run = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(3);

        // One full step for a nonzero tick_count, then reset mid-step at counter 5.
        bus.step = 1'b1;
        cyc(5);
        bus.step = 1'b0;
        cyc(8);
        chk("step2_pulse", 32'(bus.cpu_en), 32'h1);
        chk("step2_tick",  32'(bus.tick_count), 32'h1);
        cyc(5);
        bus.step = 1'b1;
        cyc(3);
        chk("step3_entered", 32'(bus.state), 32'h2);
        cyc(5);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_state",  32'(bus.state), 32'h0);
        chk("abort_cpu_en", 32'(bus.cpu_en), 32'h0);
        chk("abort_tick",   32'(bus.tick_count), 32'h0);

        // Run held through reset release: first transition at the 3rd edge.
        bus.run = 1'b1;
        cyc(2);
        bus.step = 1'b0;
        reset    = 1'b1;
        cyc(2);
        chk("release_idle_e2", 32'(bus.state), 32'h0);
        chk("release_cpu_en",  32'(bus.cpu_en), 32'h0);
        cyc(1);
        chk("release_run_e3", 32'(bus.state), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
